// File: rtl/pp_pipeline_accel_fifo_wr_arb_if.sv
// Write-side bundle between the producer stages, the round-robin arbiter and the stream FIFO.
// The arbiter takes the slave view; the producers/FIFO (or a bench) take the master view.
interface pp_pipeline_accel_fifo_wr_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int DATA_WIDTH = 11
);
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_din;
    logic [NUM_REQ-1:0]            req_full_n;
    logic                          fifo_write;
    logic [ID_W+DATA_WIDTH-1:0]    fifo_din;
    logic                          fifo_full_n;

    modport master (
        output req_write,
        output req_din,
        output fifo_full_n,
        input  req_full_n,
        input  fifo_write,
        input  fifo_din
    );

    modport slave (
        input  req_write,
        input  req_din,
        input  fifo_full_n,
        output req_full_n,
        output fifo_write,
        output fifo_din
    );
endinterface

// File: rtl/pp_pipeline_accel_fifo_wr_arb.sv
// Round-robin burst write arbiter sharing one stream FIFO among NUM_REQ producers; tags each word with its source ID.
// Optional per-producer beat/stall counters are built when PP_PIPELINE_ACCEL_ARB_STATS_EN is defined.
module pp_pipeline_accel_fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int DATA_WIDTH = 11,
    parameter int MAX_BURST  = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                arb_en,
    pp_pipeline_accel_fifo_wr_arb_if.slave      bus,
    output logic                                gnt_valid,
    output logic [ID_W-1:0]                     gnt_id
`ifdef PP_PIPELINE_ACCEL_ARB_STATS_EN
    ,
    input  logic [ID_W-1:0]                     stat_sel,
    input  logic                                stat_clr,
    output logic [31:0]                         stat_beats,
    output logic [31:0]                         stat_stall
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam logic [7:0]      LAST_BEAT = 8'(MAX_BURST - 1);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    state_e                  state_q, state_d;
    logic [ID_W-1:0]         gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]         last_gnt_q, last_gnt_d;
    logic [7:0]              beat_cnt_q, beat_cnt_d;

    logic                    gnt_valid_s;
    logic [NUM_REQ-1:0]      sel_s;
    logic                    gnt_req_s;
    logic [DATA_WIDTH-1:0]   gnt_data_s;
    logic                    beat_s;
    logic                    release_s;
    logic                    pick_found_s;
    logic [ID_W-1:0]         pick_id_s;

    // Search starts just after base and visits base itself last, so the previous owner loses ties.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    base);
        logic            found;
        logic [ID_W-1:0] win;
        int              idx;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(base) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end else begin
                found = found;
            end
        end
        return {found, win};
    endfunction

    assign gnt_valid_s = (state_q == ST_BURST);

    // Granted-producer mux: strobe, payload and per-producer ready, no added latency.
    always_comb begin
        gnt_req_s      = 1'b0;
        gnt_data_s     = '0;
        bus.req_full_n = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_s[i]          = (gnt_id_q == ID_W'(i));
            gnt_req_s         = gnt_req_s | (sel_s[i] & bus.req_write[i]);
            gnt_data_s        = gnt_data_s
                              | ({DATA_WIDTH{sel_s[i]}} & bus.req_din[i*DATA_WIDTH +: DATA_WIDTH]);
            bus.req_full_n[i] = gnt_valid_s & sel_s[i] & bus.fifo_full_n;
        end
    end

    assign beat_s         = gnt_valid_s & gnt_req_s & bus.fifo_full_n;
    assign release_s      = (beat_s && (beat_cnt_q == LAST_BEAT)) || !gnt_req_s;
    assign {pick_found_s, pick_id_s} = rr_pick(bus.req_write, last_gnt_q);

    assign bus.fifo_write = beat_s;
    assign bus.fifo_din   = {gnt_id_q, gnt_data_s};
    assign gnt_valid      = gnt_valid_s;
    assign gnt_id         = gnt_id_q;

    // Next-state logic; in BURST last_gnt equals gnt_id, so one search covers both states.
    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        last_gnt_d = last_gnt_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_en && pick_found_s) begin
                    state_d    = ST_BURST;
                    gnt_id_d   = pick_id_s;
                    last_gnt_d = pick_id_s;
                    beat_cnt_d = 8'd0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (beat_s) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
                if (release_s) begin
                    if (arb_en && pick_found_s) begin
                        state_d    = ST_BURST;
                        gnt_id_d   = pick_id_s;
                        last_gnt_d = pick_id_s;
                        beat_cnt_d = 8'd0;
                    end else begin
                        state_d    = ST_IDLE;
                        beat_cnt_d = 8'd0;
                    end
                end else begin
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                beat_cnt_d = 8'd0;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            gnt_id_q   <= '0;
            last_gnt_q <= LAST_ID;
            beat_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            last_gnt_q <= last_gnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef PP_PIPELINE_ACCEL_ARB_STATS_EN
    logic [31:0] beats_q [NUM_REQ];
    logic [31:0] stall_q [NUM_REQ];
    logic        stall_s;

    assign stall_s = gnt_valid_s & gnt_req_s & ~bus.fifo_full_n;

    // Per-producer counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                beats_q[i] <= 32'd0;
                stall_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stat_clr) begin
                    beats_q[i] <= 32'd0;
                    stall_q[i] <= 32'd0;
                end else begin
                    beats_q[i] <= beats_q[i] + {31'd0, (beat_s  & sel_s[i])};
                    stall_q[i] <= stall_q[i] + {31'd0, (stall_s & sel_s[i])};
                end
            end
        end
    end

    // Combinational read-out of the selected producer's counters.
    always_comb begin
        stat_beats = 32'd0;
        stat_stall = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_beats = stat_beats | ({32{stat_sel == ID_W'(i)}} & beats_q[i]);
            stat_stall = stat_stall | ({32{stat_sel == ID_W'(i)}} & stall_q[i]);
        end
    end
`endif

endmodule

// File: doc/pp_pipeline_accel_fifo_wr_arb.md
Name: pp_pipeline_accel_fifo_wr_arb

Overview:
- Round-robin write arbiter that shares one pipeline stream FIFO (shift-register FIFO, full_n/write handshake) among NUM_REQ producer stages.
- Grants one producer at a time for a burst of up to MAX_BURST beats.
- Prepends the source ID to each word so the consumer can demultiplex.
- Sits between the producer loops and the FIFO's write side inside the pre-processing pipeline.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- ID_W, 2, source-ID width; must satisfy 2^ID_W >= NUM_REQ.
- DATA_WIDTH, 11, producer payload width.
- MAX_BURST, 8, maximum beats per grant (1..255).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- arb_en  in  1  enables new grants; an in-progress burst still completes when low.
- req_write  in  NUM_REQ  per-producer write strobe.
- req_din  in  NUM_REQ*DATA_WIDTH  per-producer payload; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_full_n  out  NUM_REQ  per-producer ready; high only for the granted producer while the FIFO is not full.
- fifo_write  out  1  to FIFO if_write.
- fifo_din  out  ID_W+DATA_WIDTH  to FIFO if_din, formatted as {gnt_id, payload}.
- fifo_full_n  in  1  from FIFO if_full_n.
- gnt_valid  out  1  a grant is active (state BURST).
- gnt_id  out  ID_W  index of the granted producer.

Behaviour:
- Reset (async assert, sync-released by the system): state IDLE; gnt_valid=0; gnt_id=0; last_gnt=NUM_REQ-1, so producer 0 wins first; beat_cnt=0; req_full_n=0; fifo_write=0.
- Beat definition: a beat is accepted when req_write[gnt_id] & req_full_n[gnt_id].
  - req_full_n[i] = gnt_valid & (gnt_id==i) & fifo_full_n.
  - fifo_write = gnt_valid & req_write[gnt_id] & fifo_full_n.
  - fifo_din is a combinational mux of the granted producer's payload. No added latency on the data path.
- Selection:
  - Round robin: the first i with req_write[i]=1, searching from last_gnt+1 modulo NUM_REQ.
  - Grant is registered: a request seen in cycle N gives gnt_valid=1 in cycle N+1. First beat is no earlier than N+1.
- State IDLE:
  - If arb_en & |req_write: load gnt_id from the selection, last_gnt<=selection, beat_cnt<=0, go to BURST.
  - Otherwise stay in IDLE.
- State BURST, per cycle:
  - An accepted beat increments beat_cnt.
  - Release condition: (accepted beat & beat_cnt==MAX_BURST-1), or req_write[gnt_id]==0 (a bubble ends the burst).
  - fifo_full_n=0 with req_write held high does NOT release; the grant stalls and beat_cnt holds.
  - On release: if arb_en and any request is present, re-arbitrate in the same cycle, starting from gnt_id+1. The new grant is active next cycle with beat_cnt=0.
  - The releasing producer is eligible again, but only after the others have been searched, so a sole requester regains the grant back-to-back.
  - If no request is present, or arb_en=0, go to IDLE with gnt_valid=0.
- Back-to-back bursts lose no cycle: the next grant is active in the cycle after the last beat.
- Non-granted producers always see req_full_n=0 and must hold req_write and req_din stable.
- A reset assertion mid-burst drops the grant immediately; any word not accepted is the producer's responsibility.
- Out-of-range IDs (NUM_REQ..2^ID_W-1) are never granted.

Optional Feature:
- Macro: PP_PIPELINE_ACCEL_ARB_STATS_EN.
- When defined, add:
  - Input stat_sel (ID_W).
  - Input stat_clr (1).
  - Output stat_beats (32): accepted-beat count for producer stat_sel.
  - Output stat_stall (32): cycles producer stat_sel was granted with req_write=1 and fifo_full_n=0.
- Counters: one pair per producer, wrap modulo 2^32, reset to 0, cleared synchronously by stat_clr (clear wins over a same-cycle increment). Outputs are a combinational read of stat_sel.
- When not defined: no stat ports, no counters, and grant/data behaviour is identical.

Test Plan:
- Single producer 2 requests continuously for 20 beats, fifo_full_n=1, arb_en=1.
  -> Grant 2 from cycle 1; bursts of 8, 8, 4 beats with no gap cycles; fifo_din[12:11]=2 on every beat.
- All 4 requesting continuously, MAX_BURST=8.
  -> Grant order 0,1,2,3,0; each burst exactly 8 beats; fifo_write high every cycle after the first grant.
- Producer 1 granted, fifo_full_n forced 0 for 5 cycles mid-burst at beat 3.
  -> req_full_n=0 and fifo_write=0 for those 5 cycles; beat_cnt holds at 3; burst resumes and ends after 8 beats total.
- Producers 0 and 3 requesting; producer 0 drops req_write after 2 beats.
  -> Burst ends after 2 beats; gnt_id=3 in the next cycle.
- arb_en driven low during a burst of producer 2 at beat 4, with others requesting.
  -> Producer 2 finishes its 8 beats; then gnt_valid=0 and state IDLE; no grant until arb_en=1.
- reset_n pulsed low mid-burst, then [stats build] stat_sel=1 read after 10 accepted beats and 3 stall cycles.
  -> Outputs zero immediately on reset assertion; after release producer 0 gets first priority; stat_beats=10, stat_stall=3.
